// File: rtl/capture_seq_pkg.sv
// Shared types and default widths for the multi-segment ADC capture sequencer.
package capture_seq_pkg;

   localparam int SEG_W_DEF  = 16;
   localparam int SAMP_W_DEF = 20;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARMING,
      ST_WAIT_GO,
      ST_CAPTURE,
      ST_GAP,
      ST_DONE
   } state_t;

endpackage

// File: rtl/seg_timer.sv
// Saturating up-counter cleared to zero on demand; tc flags count >= terminal.
module seg_timer #(
   parameter int W = 20
) (
   input  logic         adc_clk,
   input  logic         reset_n,
   input  logic         clear,
   input  logic         enable,
   input  logic [W-1:0] terminal,
   output logic         tc
);

   logic [W-1:0] count;

   always_ff @(posedge adc_clk) begin
      if (!reset_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && (count != '1)) begin
         count <= count + 1'b1;
      end
   end

   assign tc = (count >= terminal);

endmodule

// File: rtl/capture_sequencer.sv
// Multi-segment capture sequencer: arms the trigger unit, gates FIFO writes per
// segment, and reports capture_done after the last segment or on abort.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for start_i; config latched on acceptance
// ST_ARMING  | trig_arm_o high, waiting for trig_arm_ack_i
// ST_WAIT_GO | armed_and_ready, waiting for trig_capture_go_i
// ST_CAPTURE | writing samples for the current segment
// ST_GAP     | auto mode: waiting for the period timer to start next segment
// ST_DONE    | one-cycle capture_done / done_o pulse
module capture_sequencer
   import capture_seq_pkg::*;
#(
   parameter int SEG_W  = SEG_W_DEF,
   parameter int SAMP_W = SAMP_W_DEF
) (
   input  logic              adc_clk,
   input  logic              reset_n,
   input  logic              start_i,
   input  logic              abort_i,
   input  logic [SEG_W-1:0]  num_segments_i,
   input  logic [SAMP_W-1:0] segment_samples_i,
   input  logic [SAMP_W-1:0] segment_cycles_i,
   input  logic              auto_segment_i,
   input  logic              fifo_full_i,
   input  logic              trig_arm_ack_i,
   input  logic              trig_capture_go_i,
   output logic              trig_arm_o,
   output logic              trig_armed_and_ready_o,
   output logic              trig_capture_done_o,
   output logic              sample_valid_o,
   output logic [SEG_W-1:0]  segment_count_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              overflow_o
);

   localparam logic [SEG_W-1:0]  SEG_ONE  = 1;
   localparam logic [SAMP_W-1:0] SAMP_ONE = 1;

   state_t            state, state_nx;
   logic [SEG_W-1:0]  segs_r;
   logic [SAMP_W-1:0] samples_r;
   logic [SAMP_W-1:0] cycles_r;
   logic              auto_r;
   logic [SEG_W-1:0]  seg_count_r;
   logic              overflow_r;

   logic              seg_start;
   logic              samp_tc;
   logic              per_tc;
   logic              last_seg;
   logic              seg_end;
   logic [SAMP_W-1:0] period_term;

   // Period timer runs from segment start, so a period not longer than the
   // segment collapses GAP to a single cycle.
   assign period_term = (cycles_r == '0) ? '0 : (cycles_r - SAMP_ONE);
   assign last_seg    = (seg_count_r == (segs_r - SEG_ONE));
   assign seg_end     = (state == ST_CAPTURE) && samp_tc;

   seg_timer #(.W(SAMP_W)) u_samp_timer (
      .adc_clk  (adc_clk),
      .reset_n  (reset_n),
      .clear    (state != ST_CAPTURE),
      .enable   (state == ST_CAPTURE),
      .terminal (samples_r - SAMP_ONE),
      .tc       (samp_tc)
   );

   seg_timer #(.W(SAMP_W)) u_period_timer (
      .adc_clk  (adc_clk),
      .reset_n  (reset_n),
      .clear    (seg_start),
      .enable   ((state == ST_CAPTURE) || (state == ST_GAP)),
      .terminal (period_term),
      .tc       (per_tc)
   );

   always_ff @(posedge adc_clk) begin
      if (!reset_n) begin
         state       <= ST_IDLE;
         segs_r      <= '0;
         samples_r   <= '0;
         cycles_r    <= '0;
         auto_r      <= 1'b0;
         seg_count_r <= '0;
         overflow_r  <= 1'b0;
      end else begin
         state <= state_nx;
         if ((state == ST_IDLE) && start_i) begin
            segs_r      <= (num_segments_i == '0) ? SEG_ONE : num_segments_i;
            samples_r   <= (segment_samples_i == '0) ? SAMP_ONE : segment_samples_i;
            cycles_r    <= segment_cycles_i;
            auto_r      <= auto_segment_i;
            seg_count_r <= '0;
            overflow_r  <= 1'b0;
         end else begin
            if (seg_end && !abort_i && (seg_count_r != '1)) begin
               seg_count_r <= seg_count_r + SEG_ONE;
            end
            if ((state == ST_CAPTURE) && fifo_full_i) begin
               overflow_r <= 1'b1;
            end
         end
      end
   end

   always_comb begin
      state_nx  = state;
      seg_start = 1'b0;
      case (state)
         ST_IDLE:    if (start_i) state_nx = ST_ARMING;
         ST_ARMING:  if (trig_arm_ack_i) state_nx = ST_WAIT_GO;
         ST_WAIT_GO: begin
            if (trig_capture_go_i) begin
               state_nx  = ST_CAPTURE;
               seg_start = 1'b1;
            end
         end
         ST_CAPTURE: begin
            if (samp_tc) begin
               if (last_seg)    state_nx = ST_DONE;
               else if (auto_r) state_nx = ST_GAP;
               else             state_nx = ST_WAIT_GO;
            end
         end
         ST_GAP: begin
            if (per_tc) begin
               state_nx  = ST_CAPTURE;
               seg_start = 1'b1;
            end
         end
         ST_DONE:    state_nx = ST_IDLE;
         default:    state_nx = ST_IDLE;
      endcase
      if (abort_i && (state != ST_IDLE) && (state != ST_DONE)) begin
         state_nx  = ST_DONE;
         seg_start = 1'b0;
      end
   end

   assign trig_arm_o             = (state == ST_ARMING) || (state == ST_WAIT_GO) ||
                                   (state == ST_CAPTURE) || (state == ST_GAP);
   assign trig_armed_and_ready_o = (state == ST_WAIT_GO);
   assign trig_capture_done_o    = (state == ST_DONE);
   assign done_o                 = (state == ST_DONE);
   assign busy_o                 = (state != ST_IDLE);
   assign sample_valid_o         = (state == ST_CAPTURE) && !fifo_full_i;
   assign segment_count_o        = seg_count_r;
   assign overflow_o             = overflow_r;

endmodule

// File: tb/tb_capture_sequencer.sv
// Bench for capture_sequencer: table of capture scenarios with a sample-cycle
// scoreboard, plus hand-written reset and idle-input sequences.
module tb_capture_sequencer;

   localparam int SEG_W  = 16;
   localparam int SAMP_W = 20;

   logic              adc_clk = 1'b0;
   logic              reset_n = 1'b0;
   logic              start_i = 1'b0;
   logic              abort_i = 1'b0;
   logic [SEG_W-1:0]  num_segments_i = '0;
   logic [SAMP_W-1:0] segment_samples_i = '0;
   logic [SAMP_W-1:0] segment_cycles_i = '0;
   logic              auto_segment_i = 1'b0;
   logic              fifo_full_i = 1'b0;
   logic              trig_arm_ack_i = 1'b0;
   logic              trig_capture_go_i = 1'b0;
   logic              trig_arm_o;
   logic              trig_armed_and_ready_o;
   logic              trig_capture_done_o;
   logic              sample_valid_o;
   logic [SEG_W-1:0]  segment_count_o;
   logic              busy_o;
   logic              done_o;
   logic              overflow_o;

   capture_sequencer #(.SEG_W(SEG_W), .SAMP_W(SAMP_W)) dut (
      .adc_clk                (adc_clk),
      .reset_n                (reset_n),
      .start_i                (start_i),
      .abort_i                (abort_i),
      .num_segments_i         (num_segments_i),
      .segment_samples_i      (segment_samples_i),
      .segment_cycles_i       (segment_cycles_i),
      .auto_segment_i         (auto_segment_i),
      .fifo_full_i            (fifo_full_i),
      .trig_arm_ack_i         (trig_arm_ack_i),
      .trig_capture_go_i      (trig_capture_go_i),
      .trig_arm_o             (trig_arm_o),
      .trig_armed_and_ready_o (trig_armed_and_ready_o),
      .trig_capture_done_o    (trig_capture_done_o),
      .sample_valid_o         (sample_valid_o),
      .segment_count_o        (segment_count_o),
      .busy_o                 (busy_o),
      .done_o                 (done_o),
      .overflow_o             (overflow_o)
   );

   always #5 adc_clk = ~adc_clk;

   int cyc = 0;
   always @(posedge adc_clk) cyc <= cyc + 1;

   int exp_q[$];
   int n_checks = 0;
   int n_fail = 0;
   bit mon_en = 1'b0;
   int done_cnt = 0;
   int last_done = -1;
   int mon_e;

   typedef struct {
      int nseg;
      int samp;
      int pcyc;
      bit auto_m;
      int sp;
      int ff_s;
      int ff_l;
      int abort_t;
      int exp_count;
      int exp_ovf;
   } vec_t;

   localparam int NVEC = 10;
   vec_t vecs[NVEC];

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick;
      @(posedge adc_clk);
      #1;
   endtask

   always @(negedge adc_clk) begin
      if (mon_en && sample_valid_o) begin
         if (exp_q.size() == 0) begin
            check("unexpected_sample_valid_at_cycle", cyc, -1);
         end else begin
            mon_e = exp_q.pop_front();
            check("sample_valid_cycle", cyc, mon_e);
         end
      end
      if (done_o) begin
         done_cnt++;
         last_done = cyc;
         check("trig_arm_low_in_done", int'(trig_arm_o), 0);
         check("capture_done_with_done", int'(trig_capture_done_o), 1);
      end
   end

   task automatic run_vec(input vec_t v, input int idx);
      int S, NS, P, a, done_rel, G, d0, s, m, r, t;
      bit ok, go;
      S  = (v.samp == 0) ? 1 : v.samp;
      NS = (v.nseg == 0) ? 1 : v.nseg;
      if (v.auto_m) P = (v.pcyc > S + 1) ? v.pcyc : S + 1;
      else          P = v.sp;
      a = (v.abort_t > 0) ? v.abort_t : (1 << 30);

      num_segments_i    = SEG_W'(v.nseg);
      segment_samples_i = SAMP_W'(v.samp);
      segment_cycles_i  = SAMP_W'(v.pcyc);
      auto_segment_i    = v.auto_m;
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      check($sformatf("v%0d_arm_after_start", idx), int'(trig_arm_o), 1);
      check($sformatf("v%0d_busy_after_start", idx), int'(busy_o), 1);
      check($sformatf("v%0d_count_cleared", idx), int'(segment_count_o), 0);
      check($sformatf("v%0d_overflow_cleared", idx), int'(overflow_o), 0);
      // mid-capture config changes must not matter
      num_segments_i    = 5;
      segment_samples_i = 3;
      segment_cycles_i  = 2;
      auto_segment_i    = ~v.auto_m;
      tick();
      tick();
      trig_arm_ack_i = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         tick();
         if (trig_armed_and_ready_o) ok = 1'b1;
      end
      check($sformatf("v%0d_reach_wait_go", idx), int'(ok), 1);
      if (!ok) begin
         abort_i = 1'b1;
         tick();
         abort_i = 1'b0;
         trig_arm_ack_i = 1'b0;
         repeat (3) tick();
         return;
      end

      G = cyc;
      done_rel = 0;
      for (int k = 0; k < NS; k++) begin
         s = 1 + k * P;
         for (int j = 0; j < S; j++) begin
            r = s + j;
            if (r <= a && !(v.ff_l > 0 && r >= v.ff_s && r < v.ff_s + v.ff_l))
               exp_q.push_back(G + r);
         end
         m = s + S - 1;
         if (m < a) done_rel = m + 1;
         else begin
            done_rel = a + 1;
            break;
         end
      end
      d0 = done_cnt;

      for (t = 0; t <= done_rel + 3; t++) begin
         if (v.auto_m) go = (t == 0) || (t == 3 && S >= 4);
         else go = (t / P < NS) && ((t % P == 0) || (t % P == 1 + S / 2));
         trig_capture_go_i = go;
         fifo_full_i = (v.ff_l > 0 && t >= v.ff_s && t < v.ff_s + v.ff_l);
         abort_i = (t == a);
         if (t == done_rel)     check($sformatf("v%0d_busy_in_done", idx), int'(busy_o), 1);
         if (t == done_rel + 1) check($sformatf("v%0d_busy_low_after_done", idx), int'(busy_o), 0);
         tick();
      end
      trig_capture_go_i = 1'b0;
      fifo_full_i = 1'b0;
      abort_i = 1'b0;
      trig_arm_ack_i = 1'b0;

      check($sformatf("v%0d_segment_count", idx), int'(segment_count_o), v.exp_count);
      check($sformatf("v%0d_overflow", idx), int'(overflow_o), v.exp_ovf);
      check($sformatf("v%0d_done_pulses", idx), done_cnt - d0, 1);
      check($sformatf("v%0d_done_cycle", idx), last_done, G + done_rel);
      check($sformatf("v%0d_samples_missing", idx), exp_q.size(), 0);
      exp_q.delete();
      tick();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   int d_save;

   initial begin
      //           nseg samp pcyc auto sp  ff_s ff_l abort cnt ovf
      vecs[0] = '{1,   100, 0,   0,   200, 0,   0,   0,    1,  0};
      vecs[1] = '{4,   50,  0,   0,   300, 0,   0,   0,    4,  0};
      vecs[2] = '{3,   10,  25,  1,   0,   0,   0,   0,    3,  0};
      vecs[3] = '{3,   10,  5,   1,   0,   0,   0,   0,    3,  0};
      vecs[4] = '{1,   100, 0,   0,   200, 30,  3,   0,    1,  1};
      vecs[5] = '{3,   50,  0,   0,   100, 0,   0,   140,  1,  0};
      vecs[6] = '{0,   0,   0,   0,   10,  0,   0,   0,    1,  0};
      vecs[7] = '{2,   8,   9,   1,   0,   0,   0,   0,    2,  0};
      vecs[8] = '{3,   5,   20,  1,   0,   7,   3,   12,   1,  0};
      vecs[9] = '{2,   8,   10,  1,   0,   1,   1,   0,    2,  1};

      reset_n = 1'b0;
      repeat (3) tick();
      check("reset_trig_arm", int'(trig_arm_o), 0);
      check("reset_armed_ready", int'(trig_armed_and_ready_o), 0);
      check("reset_capture_done", int'(trig_capture_done_o), 0);
      check("reset_sample_valid", int'(sample_valid_o), 0);
      check("reset_segment_count", int'(segment_count_o), 0);
      check("reset_busy", int'(busy_o), 0);
      check("reset_done", int'(done_o), 0);
      check("reset_overflow", int'(overflow_o), 0);
      reset_n = 1'b1;
      tick();
      mon_en = 1'b1;

      // abort and go while idle are ignored
      d_save = done_cnt;
      abort_i = 1'b1;
      trig_capture_go_i = 1'b1;
      repeat (3) tick();
      abort_i = 1'b0;
      trig_capture_go_i = 1'b0;
      tick();
      check("idle_inputs_busy", int'(busy_o), 0);
      check("idle_abort_no_done", done_cnt - d_save, 0);

      for (int i = 0; i < NVEC; i++) run_vec(vecs[i], i);

      // reset mid-capture: straight back to idle, no done pulse
      mon_en = 1'b0;
      d_save = done_cnt;
      num_segments_i = 2;
      segment_samples_i = 2;
      auto_segment_i = 1'b0;
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      trig_arm_ack_i = 1'b1;
      tick();
      tick();
      check("rst_seq_wait_go", int'(trig_armed_and_ready_o), 1);
      trig_capture_go_i = 1'b1;
      tick();
      trig_capture_go_i = 1'b0;
      repeat (3) tick();
      check("rst_seq_count_one", int'(segment_count_o), 1);
      trig_capture_go_i = 1'b1;
      tick();
      trig_capture_go_i = 1'b0;
      check("rst_seq_capturing", int'(sample_valid_o), 1);
      reset_n = 1'b0;
      tick();
      check("rst_seq_busy", int'(busy_o), 0);
      check("rst_seq_arm", int'(trig_arm_o), 0);
      check("rst_seq_valid", int'(sample_valid_o), 0);
      check("rst_seq_count", int'(segment_count_o), 0);
      reset_n = 1'b1;
      trig_arm_ack_i = 1'b0;
      repeat (3) tick();
      check("rst_seq_no_done", done_cnt - d_save, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
